booth_mul_sequencer: RTL and testbench
======================================

# booth_mul_sequencer

Operand-issue and result-capture stage that sits directly in front of the team's 8-bit sequential Booth multiplier. It accepts signed operand pairs over a valid/ready handshake and loads the multiplier by pulsing its reset-style load input. It waits for the multiplier's ready flag, captures the 16-bit product and queues it in a small result FIFO with a valid/ready output. It also supervises the multiplier with a timeout and a sticky error flag.

## Interface
- `FIFO_DEPTH`, default 2: result FIFO entries; power of two, ≥2.
- `TIMEOUT`, default 32: maximum RUN cycles to wait for `mul_rdy` before flagging an error.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can accept an operand pair.
- `in_a`, `in_b` in 8 each: signed operands.
- `mul_load` out 1: drives the multiplier's load/reset input; high for exactly one cycle per operation.
- `mul_a`, `mul_b` out 8 each: operands held stable to the multiplier from LOAD through RUN.
- `mul_p` in 16: multiplier product.
- `mul_rdy` in 1: multiplier done flag; level signal that is cleared by load.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_p` out 16: signed product at the FIFO head.
- `busy` out 1: FSM is not in IDLE.
- `err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, LOAD, RUN. All FSM outputs are registered.
- **IDLE**
  - `in_ready` = (FIFO count < FIFO_DEPTH).
  - On `in_valid & in_ready`: latch `in_a`/`in_b` into `mul_a`/`mul_b`, go to LOAD.
- **LOAD**
  - `mul_load`=1 for this one cycle.
  - Clear the run counter, go to RUN.
- **RUN**
  - Run counter increments every cycle.
  - `mul_rdy` is ignored in the first RUN cycle (blanking against stale ready).
  - From the second RUN cycle, `mul_rdy`=1 pushes `mul_p` into the FIFO and the FSM returns to IDLE on the same edge.
  - If the counter reaches TIMEOUT with no ready: set `err`, return to IDLE, no push.
- `in_ready`=0 in LOAD and RUN. Only one operation is ever in flight, so a push can never hit a full FIFO.
- **FIFO**
  - Pop on `out_valid & out_ready`.
  - Simultaneous push and pop is legal: count is unchanged, pointers wrap modulo FIFO_DEPTH.
  - `out_p` shows the head entry and is stable while `out_valid & !out_ready`.
- **Width:** products are passed through unmodified as 16-bit two's complement; no sign or extension logic in this block.
- **`err`:** cleared only by `reset`. Operation continues normally after a timeout.
- **Reset (any time, including mid-RUN):** state=IDLE, `mul_load`=0, `mul_a`=`mul_b`=0, FIFO empty, `out_valid`=0, `out_p`=0, `busy`=0, `err`=0, `in_ready`=1 once reset is released. Any in-flight operation is dropped.

## Timing
- Accept edge E0, LOAD cycle E0–E1, RUN from E1.
- A conforming multiplier computes on edges E2..E17 and raises `mul_rdy` after E18.
- The push occurs at E19, so `out_valid` rises 19 cycles after the accept when the FIFO was empty.
- Peak throughput: one operation per 20 cycles, since IDLE lasts at least one cycle.
- `out_valid` does not depend combinationally on `out_ready`. `in_ready` does not depend combinationally on `in_valid`.

## Structure
- Package `booth_mul_seq_pkg`:
  - state enum (IDLE/LOAD/RUN);
  - `MUL_W`=8 and `PROD_W`=16;
  - default TIMEOUT;
  - nominal latency constant 19 for benches.
- Sub-module `booth_mul_result_fifo`: parameterised synchronous FIFO with push, pop, count, full and empty.
- The FSM, operand registers and timeout counter live in the top level.

## Test plan
- **Single op:** `in_a`=3, `in_b`=-2, multiplier model attached → `mul_load` is a 1-cycle pulse; `out_p`=16'hFFFA with `out_valid` 19 cycles after the accept.
- **Corner products:** -128×-128 → 16'h4000; 127×127 → 16'h3F01; 0×-1 → 16'h0000; results come out in issue order.
- **Backpressure:** hold `out_ready`=0 and issue 3 ops → after two results `in_ready` stays 0; one pop re-enables accept; the third result follows.
- **Simultaneous push/pop:** FIFO holding 1 entry, pop on the push edge → count stays 1 and the data order is preserved.
- **Timeout:** multiplier model never raises `mul_rdy` → `err`=1 after 32 RUN cycles, no `out_valid`, FSM back in IDLE; a following op completes normally with `err` still 1.
- **Reset mid-RUN:** assert `reset` at RUN cycle 8 → all outputs take their reset values immediately; the dropped op never appears at the output.

Source files
------------

// File: rtl/booth_mul_seq_pkg.sv
// booth_mul_seq_pkg: shared types and constants for the Booth multiplier sequencer
package booth_mul_seq_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    localparam int MUL_W       = 8;
    localparam int PROD_W      = 16;
    localparam int DEF_TIMEOUT = 32;
    localparam int NOM_LATENCY = 19;
endpackage

// File: rtl/booth_mul_result_fifo.sv
// booth_mul_result_fifo: synchronous result FIFO with push, pop, count, full and empty
module booth_mul_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: issues operands to the Booth multiplier, supervises it and queues products
module booth_mul_sequencer
    import booth_mul_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MUL_W-1:0]  in_a,
    input  logic [MUL_W-1:0]  in_b,
    output logic              mul_load,
    output logic [MUL_W-1:0]  mul_a,
    output logic [MUL_W-1:0]  mul_b,
    input  logic [PROD_W-1:0] mul_p,
    input  logic              mul_rdy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_p,
    output logic              busy,
    output logic              err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t           state_q, state_d;
    logic [MUL_W-1:0] a_q, a_d, b_q, b_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             load_q, load_d, in_ready_q, in_ready_d, busy_q, busy_d, err_q, err_d;
    logic             push, pop, full, empty;
    logic [CW-1:0]    count, cnt_nxt;
    assign pop = !empty && out_ready;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (in_valid && in_ready_q && !full) begin
                a_d     = in_a;
                b_d     = in_b;
                state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // first RUN cycle blanks a stale ready left over from the previous operation
                if (cnt_q != '0 && mul_rdy) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_nxt    = count + CW'(push) - CW'(pop);
        load_d     = state_d == LOAD;
        busy_d     = state_d != IDLE;
        in_ready_d = state_d == IDLE && cnt_nxt != CW'(FIFO_DEPTH);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            load_q     <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            load_q     <= load_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end
    booth_mul_result_fifo #(.DEPTH(FIFO_DEPTH), .W(PROD_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (mul_p),
        .dout  (out_p),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    assign in_ready  = in_ready_q;
    assign mul_load  = load_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign out_valid = !empty;
    assign busy      = busy_q;
    assign err       = err_q;
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: directed vector bench with a cycle-accurate Booth multiplier model
module tb_booth_mul_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        mul_load;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_p;
    logic        mul_rdy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_p;
    logic        busy, err;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          never_rdy = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    booth_mul_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_load  (mul_load),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .mul_rdy   (mul_rdy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .err       (err)
    );
    // multiplier model: load sampled at E1, computes E2..E17, ready after E18
    logic        m_run = 1'b0;
    logic        m_rdy = 1'b0;
    logic [4:0]  m_cnt = '0;
    logic [15:0] m_p = '0;
    always @(posedge clk) begin
        if (mul_load) begin
            m_run <= 1'b1;
            m_cnt <= 5'd1;
            m_rdy <= 1'b0;
        end else if (m_run) begin
            if (m_cnt == 5'd17) begin
                m_run <= 1'b0;
                m_rdy <= !never_rdy;
                m_p   <= 16'($signed(mul_a)) * 16'($signed(mul_b));
            end else m_cnt <= m_cnt + 5'd1;
        end
    end
    assign mul_rdy = m_rdy;
    assign mul_p   = m_p;
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;
    vec_t vecs [8];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue_wait_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask
    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("wait_out_valid", 32'(out_valid), 1);
    endtask
    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs[0] = '{8'h03, 8'hFE, 16'hFFFA};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[3] = '{8'h00, 8'hFF, 16'h0000};
        vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[5] = '{8'h7F, 8'h80, 16'hC080};
        vecs[6] = '{8'h05, 8'h07, 16'h0023};
        vecs[7] = '{8'hF9, 8'h09, 16'hFFC1};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mul_load", 32'(mul_load), 0);
        chk("rst_mul_ab", {16'h0, mul_a, mul_b}, 0);
        chk("rst_out_p", 32'(out_p), 0);
        // single op: load pulse shape and operand hold
        issue(8'h03, 8'hFE);
        chk("single_load_hi", 32'(mul_load), 1);
        chk("single_mul_ab", {16'h0, mul_a, mul_b}, 32'h03FE);
        chk("single_in_ready", 32'(in_ready), 0);
        chk("single_busy", 32'(busy), 1);
        @(negedge clk);
        chk("single_load_lo", 32'(mul_load), 0);
        wait_valid();
        chk("single_latency", 32'(cyc - acc_cyc), 19);
        chk("single_out_p", 32'(out_p), 32'hFFFA);
        pop();
        chk("single_drained", 32'(out_valid), 0);
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_valid();
            chk($sformatf("vec%0d_latency", i), 32'(cyc - acc_cyc), 19);
            chk($sformatf("vec%0d_out_p", i), 32'(out_p), 32'(vecs[i].p));
            pop();
            chk($sformatf("vec%0d_drained", i), 32'(out_valid), 0);
        end
        // backpressure: two results fill the FIFO, third op blocked until one pop
        issue(8'h80, 8'h80);
        wait_valid();
        chk("bp_first", 32'(out_p), 32'h4000);
        issue(8'h7F, 8'h7F);
        repeat (22) @(negedge clk);
        chk("bp_full_in_ready", 32'(in_ready), 0);
        chk("bp_head_stable", 32'(out_p), 32'h4000);
        in_valid = 1'b1;
        in_a     = 8'h00;
        in_b     = 8'hFF;
        repeat (10) @(negedge clk);
        chk("bp_blocked_busy", 32'(busy), 0);
        chk("bp_blocked_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_second", 32'(out_p), 32'h3F01);
        chk("bp_reenabled", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
        chk("bp_third_accepted", 32'(busy), 1);
        repeat (20) @(negedge clk);
        chk("bp_head_before_pop", 32'(out_p), 32'h3F01);
        pop();
        chk("bp_third_valid", 32'(out_valid), 1);
        chk("bp_third", 32'(out_p), 32'h0000);
        pop();
        chk("bp_drained", 32'(out_valid), 0);
        // simultaneous push and pop with one entry held
        issue(8'h05, 8'h07);
        wait_valid();
        issue(8'hF9, 8'h09);
        while (cyc < acc_cyc + 18) @(negedge clk);
        chk("pp_head_pre", 32'(out_p), 32'h0023);
        chk("pp_valid_pre", 32'(out_valid), 1);
        pop();
        chk("pp_valid_post", 32'(out_valid), 1);
        chk("pp_head_post", 32'(out_p), 32'hFFC1);
        chk("pp_idle", 32'(busy), 0);
        pop();
        chk("pp_count_one", 32'(out_valid), 0);
        // timeout: multiplier never signals ready
        never_rdy = 1'b1;
        issue(8'h11, 8'h22);
        while (cyc < acc_cyc + 32) @(negedge clk);
        chk("to_err_pre", 32'(err), 0);
        chk("to_busy_pre", 32'(busy), 1);
        @(negedge clk);
        chk("to_err", 32'(err), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_no_push", 32'(out_valid), 0);
        chk("to_in_ready", 32'(in_ready), 1);
        never_rdy = 1'b0;
        issue(8'h02, 8'h03);
        wait_valid();
        chk("to_after_latency", 32'(cyc - acc_cyc), 19);
        chk("to_after_out_p", 32'(out_p), 32'h0006);
        chk("to_err_sticky", 32'(err), 1);
        pop();
        // reset mid-RUN: dropped op must never reach the output
        issue(8'h04, 8'h04);
        while (cyc < acc_cyc + 8) @(negedge clk);
        chk("mr_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_err", 32'(err), 0);
        chk("mr_mul_ab", {16'h0, mul_a, mul_b}, 0);
        chk("mr_mul_load", 32'(mul_load), 0);
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_out_p", 32'(out_p), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_in_ready", 32'(in_ready), 1);
        repeat (30) @(negedge clk);
        chk("mr_dropped", 32'(out_valid), 0);
        issue(8'h01, 8'hFF);
        wait_valid();
        chk("mr_next_latency", 32'(cyc - acc_cyc), 19);
        chk("mr_next_out_p", 32'(out_p), 32'hFFFF);
        pop();
        chk("mr_drained", 32'(out_valid), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
